// File: rtl/jedro_1_prefetch_ifu.sv
// jedro_1 prefetching instruction fetch unit.
// Fetches instruction words over a stb/ack/err bus into a small FIFO and
// presents the FIFO head to the decoder. Jumps and traps flush the FIFO.
// Bus faults and misaligned jump targets reach the decoder as exception
// entries instead of instructions.
module jedro_1_prefetch_ifu #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] BOOT_ADDR  = 32'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  jmp_instr_i,
  input  logic [DATA_WIDTH-1:0] jmp_address_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] addr_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  exception_o,
  output logic [1:0]            exc_cause_o,
  output logic                  ram_stb_o,
  output logic [DATA_WIDTH-1:0] ram_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  ram_ack_i,
  input  logic                  ram_err_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_BUS_ERR  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_DRAIN,
    S_HALT
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
  logic                  drain_halt_q, drain_halt_d;

  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] addr_mem  [FIFO_DEPTH];
  logic [1:0]            cause_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q;

  logic                  push, pop, flush;
  logic [DATA_WIDTH-1:0] push_instr, push_addr;
  logic [1:0]            push_cause;
  logic [PTR_W-1:0]      wr_idx;
  logic [CNT_W-1:0]      count_after;

  logic bus_done, outstanding, jmp_misaligned;

  assign bus_done       = ram_ack_i | ram_err_i;
  assign outstanding    = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign jmp_misaligned = (jmp_address_i[1:0] != 2'b00);

  // The outstanding request's address lives in pc_q until it completes, so
  // the bus address stays stable through REQ and DRAIN.
  assign ram_stb_o  = outstanding;
  assign ram_addr_o = pc_q;

  assign valid_o     = (count_q != '0);
  assign instr_o     = instr_mem[rd_ptr_q];
  assign addr_o      = addr_mem[rd_ptr_q];
  assign exc_cause_o = cause_mem[rd_ptr_q];
  assign exception_o = (cause_mem[rd_ptr_q] != CAUSE_NONE);

  // A jump flushes the FIFO, so it suppresses a pop in the same cycle.
  assign pop    = valid_o & ready_i & ~jmp_instr_i;
  assign wr_idx = flush ? '0 : wr_ptr_q;

  // Occupancy once this cycle's ack push and any pop have happened; a
  // back-to-back request is only issued if that leaves a slot free.
  assign count_after = count_q + CNT_W'(1) - CNT_W'(pop);

  // Next-state, PC update and FIFO push decisions.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    drain_halt_d = drain_halt_q;
    push         = 1'b0;
    push_instr   = '0;
    push_addr    = pc_q;
    push_cause   = CAUSE_NONE;
    flush        = 1'b0;

    if (jmp_instr_i) begin
      flush = 1'b1;
      if (jmp_misaligned) begin
        push       = 1'b1;
        push_addr  = jmp_address_i;
        push_cause = CAUSE_MISALIGN;
      end
      if (outstanding && !bus_done) begin
        // The bus cannot be aborted: wait for the response, then redirect
        // (or halt, if the target was misaligned).
        state_d      = S_DRAIN;
        tgt_d        = jmp_address_i;
        drain_halt_d = jmp_misaligned;
      end else if (jmp_misaligned) begin
        state_d = S_HALT;
      end else begin
        state_d = S_IDLE;
        pc_d    = jmp_address_i;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q < DEPTH_C) state_d = S_REQ;
        end
        S_REQ: begin
          if (ram_err_i) begin
            push       = 1'b1;
            push_cause = CAUSE_BUS_ERR;
            state_d    = S_HALT;
          end else if (ram_ack_i) begin
            push       = 1'b1;
            push_instr = ram_rdata_i;
            pc_d       = pc_q + DATA_WIDTH'(4);
            state_d    = (count_after < DEPTH_C) ? S_REQ : S_IDLE;
          end
        end
        S_DRAIN: begin
          if (bus_done) begin
            drain_halt_d = 1'b0;
            if (drain_halt_q) begin
              state_d = S_HALT;
            end else begin
              state_d = S_IDLE;
              pc_d    = tgt_q;
            end
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM state, PC and pending redirect target.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      pc_q         <= BOOT_ADDR;
      tgt_q        <= BOOT_ADDR;
      drain_halt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tgt_q        <= tgt_d;
      drain_halt_q <= drain_halt_d;
    end
  end

  // Prefetch FIFO storage, pointers and occupancy; flush restarts at slot 0.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
        cause_mem[i] <= CAUSE_NONE;
      end
    end else begin
      if (push) begin
        instr_mem[wr_idx] <= push_instr;
        addr_mem[wr_idx]  <= push_addr;
        cause_mem[wr_idx] <= push_cause;
      end
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= push ? PTR_W'(1) : '0;
        count_q  <= push ? CNT_W'(1) : '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_jedro_1_prefetch_ifu.sv
// Directed bench for jedro_1_prefetch_ifu. The bus slave returns
// rdata = address + 0x1000_0000, so every expected instruction is a constant.
module tb_jedro_1_prefetch_ifu;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        jmp_instr_i;
  logic [31:0] jmp_address_i;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        valid_o;
  logic        ready_i;
  logic        exception_o;
  logic [1:0]  exc_cause_o;
  logic        ram_stb_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_rdata_i;
  logic        ram_ack_i;
  logic        ram_err_i;

  logic        ack_auto;
  logic        ack_man;
  logic        err_en;
  logic [31:0] err_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  // Bus slave: zero-wait when ack_auto, otherwise acked by hand.
  assign ram_rdata_i = ram_addr_o + 32'h1000_0000;
  assign ram_err_i   = err_en & ram_stb_o & (ram_addr_o == err_addr);
  assign ram_ack_i   = ack_auto ? (ram_stb_o & ~ram_err_i) : ack_man;

  jedro_1_prefetch_ifu dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .jmp_instr_i   (jmp_instr_i),
    .jmp_address_i (jmp_address_i),
    .instr_o       (instr_o),
    .addr_o        (addr_o),
    .valid_o       (valid_o),
    .ready_i       (ready_i),
    .exception_o   (exception_o),
    .exc_cause_o   (exc_cause_o),
    .ram_stb_o     (ram_stb_o),
    .ram_addr_o    (ram_addr_o),
    .ram_rdata_i   (ram_rdata_i),
    .ram_ack_i     (ram_ack_i),
    .ram_err_i     (ram_err_i)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold reset for two cycles, then release just after a rising edge.
  task automatic do_reset(input logic rdy, input logic auto);
    rstn_i      = 1'b0;
    jmp_instr_i = 1'b0;
    ack_man     = 1'b0;
    err_en      = 1'b0;
    ready_i     = rdy;
    ack_auto    = auto;
    tick();
    tick();
    rstn_i = 1'b1;
  endtask

  initial begin
    rstn_i        = 1'b0;
    jmp_instr_i   = 1'b0;
    jmp_address_i = 32'h0;
    ready_i       = 1'b0;
    ack_auto      = 1'b0;
    ack_man       = 1'b0;
    err_en        = 1'b0;
    err_addr      = 32'h8000_0008;

    // Reset state
    tick();
    tick();
    chk("rst_valid", valid_o, 0);
    chk("rst_stb", ram_stb_o, 0);
    chk("rst_ram_addr", ram_addr_o, 32'h8000_0000);
    chk("rst_instr", instr_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_exc", exception_o, 0);
    chk("rst_cause", exc_cause_o, 0);

    // Streaming with zero-wait slave and ready decoder
    do_reset(1'b1, 1'b1);
    tick();
    chk("s1_stb", ram_stb_o, 1);
    chk("s1_ram_addr", ram_addr_o, 32'h8000_0000);
    chk("s1_valid_early", valid_o, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("s1_valid", valid_o, 1);
      chk("s1_addr", addr_o, 32'h8000_0000 + 32'(4 * k));
      chk("s1_instr", instr_o, 32'h9000_0000 + 32'(4 * k));
      chk("s1_ram_addr_next", ram_addr_o, 32'h8000_0004 + 32'(4 * k));
    end

    // Back-pressure: FIFO fills with exactly four requests
    do_reset(1'b0, 1'b1);
    begin
      int reqs;
      reqs = 0;
      for (int k = 0; k < 7; k++) begin
        tick();
        if (ram_stb_o) reqs++;
      end
      chk("s2_req_count", 32'(reqs), 4);
    end
    chk("s2_stb_full", ram_stb_o, 0);
    chk("s2_valid", valid_o, 1);
    chk("s2_head", addr_o, 32'h8000_0000);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("s2_head_after_pop", addr_o, 32'h8000_0004);
    chk("s2_stb_pop_cycle", ram_stb_o, 0);
    tick();
    chk("s2_refill_stb", ram_stb_o, 1);
    chk("s2_refill_addr", ram_addr_o, 32'h8000_0010);
    tick();
    chk("s2_stb_off_again", ram_stb_o, 0);
    tick();
    chk("s2_stb_stays_off", ram_stb_o, 0);
    chk("s2_head_still", addr_o, 32'h8000_0004);

    // Jump while a slow request is outstanding
    do_reset(1'b1, 1'b0);
    tick();
    chk("s3_stb", ram_stb_o, 1);
    jmp_instr_i   = 1'b1;
    jmp_address_i = 32'h8000_0100;
    tick();
    jmp_instr_i = 1'b0;
    chk("s3_drain_stb", ram_stb_o, 1);
    chk("s3_drain_addr", ram_addr_o, 32'h8000_0000);
    chk("s3_drain_valid", valid_o, 0);
    tick();
    chk("s3_drain_stb2", ram_stb_o, 1);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("s3_post_stb", ram_stb_o, 0);
    chk("s3_post_valid", valid_o, 0);
    chk("s3_post_addr", ram_addr_o, 32'h8000_0100);
    tick();
    chk("s3_new_stb", ram_stb_o, 1);
    chk("s3_new_addr", ram_addr_o, 32'h8000_0100);
    chk("s3_no_stale", valid_o, 0);
    ack_auto = 1'b1;
    tick();
    chk("s3_new_valid", valid_o, 1);
    chk("s3_new_head", addr_o, 32'h8000_0100);
    chk("s3_new_instr", instr_o, 32'h9000_0100);

    // Bus error on the third fetch
    do_reset(1'b0, 1'b1);
    err_en = 1'b1;
    tick();
    tick();
    tick();
    chk("s4_err_addr", ram_addr_o, 32'h8000_0008);
    tick();
    chk("s4_halt_stb", ram_stb_o, 0);
    chk("s4_head0", addr_o, 32'h8000_0000);
    ready_i = 1'b1;
    tick();
    chk("s4_head1", addr_o, 32'h8000_0004);
    chk("s4_head1_instr", instr_o, 32'h9000_0004);
    chk("s4_head1_exc", exception_o, 0);
    tick();
    ready_i = 1'b0;
    chk("s4_exc_valid", valid_o, 1);
    chk("s4_exc", exception_o, 1);
    chk("s4_cause", exc_cause_o, 2'b01);
    chk("s4_exc_addr", addr_o, 32'h8000_0008);
    chk("s4_exc_instr", instr_o, 0);
    tick();
    chk("s4_halt_stb2", ram_stb_o, 0);
    err_en        = 1'b0;
    jmp_instr_i   = 1'b1;
    jmp_address_i = 32'h8000_0000;
    tick();
    jmp_instr_i = 1'b0;
    chk("s4_flush_valid", valid_o, 0);
    tick();
    chk("s4_resume_stb", ram_stb_o, 1);
    chk("s4_resume_addr", ram_addr_o, 32'h8000_0000);

    // Misaligned jump together with a pop, request completing that cycle
    do_reset(1'b0, 1'b1);
    tick();
    tick();
    tick();
    chk("s5_pre_head", addr_o, 32'h8000_0000);
    jmp_instr_i   = 1'b1;
    jmp_address_i = 32'h8000_0102;
    ready_i       = 1'b1;
    tick();
    jmp_instr_i = 1'b0;
    ready_i     = 1'b0;
    chk("s5_valid", valid_o, 1);
    chk("s5_exc", exception_o, 1);
    chk("s5_cause", exc_cause_o, 2'b10);
    chk("s5_addr", addr_o, 32'h8000_0102);
    chk("s5_instr", instr_o, 0);
    chk("s5_stb", ram_stb_o, 0);
    tick();
    tick();
    chk("s5_stb_halt", ram_stb_o, 0);
    chk("s5_head_kept", addr_o, 32'h8000_0102);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    chk("s5_empty", valid_o, 0);

    // Reset asserted mid-transaction
    do_reset(1'b1, 1'b0);
    tick();
    chk("s6_stb_before", ram_stb_o, 1);
    rstn_i = 1'b0;
    #1;
    chk("s6_stb_drop", ram_stb_o, 0);
    ack_man = 1'b1;
    tick();
    tick();
    chk("s6_stb_in_rst", ram_stb_o, 0);
    chk("s6_valid_in_rst", valid_o, 0);
    ack_man = 1'b0;
    rstn_i  = 1'b1;
    tick();
    chk("s6_restart_stb", ram_stb_o, 1);
    chk("s6_restart_addr", ram_addr_o, 32'h8000_0000);
    chk("s6_ack_ignored", valid_o, 0);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("s6_valid", valid_o, 1);
    chk("s6_head", addr_o, 32'h8000_0000);
    chk("s6_instr", instr_o, 32'h9000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
